bus_master_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares the register bus between NREQ requesters, e.g. a host-interface bridge and an on-chip sequencer.
- Accepts one read or write per grant and drives a single-cycle bus_re or bus_we strobe to the register slaves.
- Waits for the matching rd_ack or wr_ack (registered slaves answer one cycle after the strobe). A timeout counter terminates hung accesses.
- Sits between the requesters and the bus fabric that fans out to all register slaves and ORs their returns.

---
 rtl/bus_master_arb_pkg.sv | 12 +
 rtl/bus_master_arb_rr_arbiter.sv | 26 ++
 rtl/bus_master_arb.sv | 83 ++++++++
 tb/tb_bus_master_arb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_arb_pkg.sv
// bus_master_arb_pkg: shared bus widths, FSM encodings and constants for the bus master arbiter
package bus_master_arb_pkg;
  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 32;
  localparam int CNT_WIDTH = 16;
  localparam int TIMEOUT_RDATA = 0;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;
endpackage

// File: rtl/bus_master_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select, searching upward from last_grant+1 with wrap
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(last_grant) + k) % NREQ;
      if (!any && req[j]) begin
        any = 1'b1;
        gnt[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/bus_master_arb.sv
// bus_master_arb: round-robin register-bus master issuing one strobed access per grant with ack timeout
module bus_master_arb
  import bus_master_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                       bus_clk,
  input  logic                       bus_reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            done,
  output logic                       err,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [ADDR_WIDTH-1:0]      bus_addr,
  output logic [DATA_WIDTH-1:0]      bus_wr_data,
  output logic                       bus_re,
  output logic                       bus_we,
  input  logic [DATA_WIDTH-1:0]      bus_rd_data,
  input  logic                       bus_rd_ack,
  input  logic                       bus_wr_ack
);
  localparam int IW = $clog2(NREQ);
  state_t state, state_nx;
  logic [NREQ-1:0] win_gnt, own_gnt;
  logic [IW-1:0] win_idx, last_grant;
  logic [CNT_WIDTH-1:0] cnt;
  logic win_any, own_we, ack, timed_out;
  // the owner's req is still up during its done cycle, so it is masked to avoid a duplicate grant
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req & ~done),
    .last_grant(last_grant),
    .gnt       (win_gnt),
    .idx       (win_idx),
    .any       (win_any)
  );
  assign ack = own_we ? bus_wr_ack : bus_rd_ack;
  assign timed_out = cnt == CNT_WIDTH'(TIMEOUT - 1);
  assign bus_re = state == ISSUE && !own_we;
  assign bus_we = state == ISSUE && own_we;
  always_comb begin
    state_nx = state == IDLE  ? (win_any ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               (ack || timed_out) ? IDLE : WAIT;
  end
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      state <= IDLE;
      last_grant <= IW'(NREQ - 1);
      own_gnt <= '0;
      own_we <= 1'b0;
      bus_addr <= '0;
      bus_wr_data <= '0;
      cnt <= '0;
      done <= '0;
      err <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      done <= '0;
      if (state == IDLE && win_any) begin
        own_gnt <= win_gnt;
        own_we <= req_we[win_idx];
        bus_addr <= req_addr[int'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH] & ~ADDR_WIDTH'(3);
        bus_wr_data <= req_wdata[int'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
        last_grant <= win_idx;
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (ack || timed_out) begin
          done <= own_gnt;
          err <= !ack;
          rdata <= !ack ? DATA_WIDTH'(TIMEOUT_RDATA) : own_we ? rdata : bus_rd_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_bus_master_arb.sv
// tb_bus_master_arb: directed self-checking bench for bus_master_arb with a registered slave model
module tb_bus_master_arb;
  logic bus_clk = 1'b0;
  logic bus_reset = 1'b1;
  logic [1:0] req = '0, req_we = '0, done;
  logic [15:0] addr0 = '0, addr1 = '0, bus_addr;
  logic [31:0] wdata0 = '0, wdata1 = '0, rdata, bus_wr_data, bus_rd_data;
  logic err, bus_re, bus_we, bus_rd_ack, bus_wr_ack;
  logic slave_en = 1'b1, slave_wrong = 1'b0, slave_map = 1'b0;
  logic [31:0] slave_rdata = '0, man_data = '0, auto_data = '0;
  logic auto_rd = 1'b0, auto_wr = 1'b0, man_rd = 1'b0;
  int errors = 0, checks = 0;

  bus_master_arb #(.NREQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .bus_clk    (bus_clk),
    .bus_reset  (bus_reset),
    .req        (req),
    .req_we     (req_we),
    .req_addr   ({addr1, addr0}),
    .req_wdata  ({wdata1, wdata0}),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .bus_addr   (bus_addr),
    .bus_wr_data(bus_wr_data),
    .bus_re     (bus_re),
    .bus_we     (bus_we),
    .bus_rd_data(bus_rd_data),
    .bus_rd_ack (bus_rd_ack),
    .bus_wr_ack (bus_wr_ack)
  );

  always #5 bus_clk = ~bus_clk;

  // registered slave: answers one cycle after the strobe; slave_wrong swaps the ack type
  always @(posedge bus_clk) begin
    auto_rd <= slave_en && !slave_wrong && bus_re;
    auto_wr <= slave_en && (slave_wrong ? bus_re : bus_we);
    auto_data <= (slave_en && !slave_wrong && bus_re) ?
                 (slave_map ? (32'hD000_0000 | 32'(bus_addr)) : slave_rdata) : '0;
  end
  assign bus_rd_ack = auto_rd | man_rd;
  assign bus_wr_ack = auto_wr;
  assign bus_rd_data = auto_data | man_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge bus_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cyc, last_t, adj;
    logic prev_str;
    step(); step();
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_re", bus_re, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    bus_reset = 1'b0;
    step();

    // single read from requester 0
    slave_rdata = 32'hA5A5_0001;
    addr0 = 16'h0013; req_we = 2'b00; req = 2'b01;
    step();
    check("rd_re", bus_re, 1);
    check("rd_we", bus_we, 0);
    check("rd_addr", bus_addr, 16'h0010);
    step();
    check("rd_re_once", bus_re, 0);
    check("rd_no_early_done", done, 0);
    step();
    check("rd_done", done, 2'b01);
    check("rd_err", err, 0);
    check("rd_rdata", rdata, 32'hA5A5_0001);
    req = 2'b00;
    step();
    check("rd_done_pulse", done, 0);
    check("rd_rdata_hold", rdata, 32'hA5A5_0001);

    // single write from requester 1
    addr1 = 16'h0040; wdata1 = 32'h1234_5678; req_we = 2'b10; req = 2'b10;
    step();
    check("wr_we", bus_we, 1);
    check("wr_re", bus_re, 0);
    check("wr_addr", bus_addr, 16'h0040);
    check("wr_data", bus_wr_data, 32'h1234_5678);
    step();
    check("wr_we_once", bus_we, 0);
    step();
    check("wr_done", done, 2'b10);
    check("wr_err", err, 0);
    req = 2'b00; req_we = 2'b00;
    step();

    // contention: both requesters read continuously
    slave_map = 1'b1; addr0 = 16'h0100; addr1 = 16'h0200; req = 2'b11;
    n = 0; cyc = 0; last_t = 0; adj = 0; prev_str = 1'b0;
    while (n < 6 && cyc < 60) begin
      step(); cyc++;
      if ((bus_re | bus_we) && prev_str) adj++;
      prev_str = bus_re | bus_we;
      if (|done) begin
        check("rr_grant", done, (n % 2) ? 2'b10 : 2'b01);
        check("rr_rdata", rdata, (n % 2) ? 32'hD000_0200 : 32'hD000_0100);
        if (n > 0) check("rr_gap", cyc - last_t, 3);
        last_t = cyc; n++;
        if (n == 6) req = 2'b00;
      end
    end
    check("rr_count", n, 6);
    check("rr_adjacent", adj, 0);
    slave_map = 1'b0;
    step(); step();

    // timeout: no slave answers
    slave_en = 1'b0; addr0 = 16'h0300; req = 2'b01;
    step();
    check("to_re", bus_re, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("to_wait", done, 0);
    end
    step();
    check("to_done", done, 2'b01);
    check("to_err", err, 1);
    check("to_rdata", rdata, 0);
    req = 2'b00; man_rd = 1'b1; man_data = 32'hBEEF_0000;
    step();
    man_rd = 1'b0; man_data = '0;
    check("late_ack_done", done, 0);
    check("late_ack_rdata", rdata, 0);
    step();
    check("late_ack_idle", bus_re, 0);

    // read receiving only a write ack stays in WAIT, then times out
    slave_en = 1'b1; slave_wrong = 1'b1; addr0 = 16'h0304; req = 2'b01;
    step();
    check("wa_re", bus_re, 1);
    step(); step();
    check("wa_stays", done, 0);
    step(); step(); step();
    check("wa_done", done, 2'b01);
    check("wa_err", err, 1);
    req = 2'b00; slave_wrong = 1'b0; slave_en = 1'b0;
    step();

    // matching ack on the final WAIT cycle wins over the timeout
    addr1 = 16'h0044; req = 2'b10;
    step();
    check("tc_re", bus_re, 1);
    step(); step(); step(); step();
    man_rd = 1'b1; man_data = 32'hCAFE_F00D;
    step();
    man_rd = 1'b0; man_data = '0;
    check("tc_done", done, 2'b10);
    check("tc_err", err, 0);
    check("tc_rdata", rdata, 32'hCAFE_F00D);
    req = 2'b00;
    step();

    // reset in WAIT aborts silently and restores requester 0 priority
    slave_en = 1'b1; slave_rdata = 32'h1111_1111; addr0 = 16'h0500; req = 2'b01;
    step();
    check("rs_re", bus_re, 1);
    step();
    bus_reset = 1'b1; req = 2'b00;
    step();
    check("rs_done", done, 0);
    check("rs_re_low", bus_re, 0);
    check("rs_we_low", bus_we, 0);
    bus_reset = 1'b0; man_rd = 1'b1;
    step();
    man_rd = 1'b0;
    check("rs_late_done", done, 0);
    check("rs_late_rdata", rdata, 0);
    slave_rdata = 32'h2222_2222; addr0 = 16'h0600; addr1 = 16'h0700; req = 2'b11;
    step();
    check("rs_prio_addr", bus_addr, 16'h0600);
    step(); step();
    check("rs_prio_done", done, 2'b01);
    check("rs_prio_rdata", rdata, 32'h2222_2222);
    req = 2'b00;
    step(); step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
